ram_rr_arbiter: RTL and testbench
=================================

// Module: ram_rr_arbiter
// PURPOSE
// - Arbitrates NREQ single-word requesters (icache/dcache ports of all cores) onto the one RAM port.
// - Replaces the ad hoc fixed-priority muxing in the coherence controller.
// - Registered grant, round-robin fairness, grant held until RAM reports ACCESS.
// - Sits between the cache-side request buses and ram_if; uses word_t/ramstate_t from cpu_types_pkg.
// PARAMETERS
// - NREQ   2   number of requesters, 2..8; index 0 is the lowest index
// - IDW    $clog2(NREQ)   width of grant index (derived, not overridable)
// PORTS
// - CLK       in   1          clock, rising edge
// - nRST      in   1          reset, asynchronous, active-low
// - ren       in   NREQ       per-requester read request
// - wen       in   NREQ       per-requester write request (wen wins over ren on same requester)
// - addr      in   NREQx32    per-requester word address
// - store     in   NREQx32    per-requester write data
// - rwait     out  NREQ       per-requester wait; 0 for exactly the completing cycle
// - load      out  NREQx32    per-requester read data, valid when rwait[i]==0
// - ramREN    out  1          RAM read enable
// - ramWEN    out  1          RAM write enable
// - ramaddr   out  32         RAM address
// - ramstore  out  32         RAM write data
// - ramload   in   32         RAM read data
// - ramstate  in   ramstate_t FREE/BUSY/ACCESS/ERROR
// - busy      out  1          1 while in GRANT
// - gnt_id    out  IDW        granted requester index; 0 when idle
// BEHAVIOUR
// - Reset: state=IDLE, ptr=NREQ-1, gnt_id=0, busy=0, rwait='1, load='0, ram* outputs 0.
// - req[i] = ren[i] | wen[i].
// - IDLE:
//   - No RAM enables driven; rwait all 1.
//   - If any req: next gnt = first i with req[i], searching ptr+1, ptr+2, ... modulo NREQ.
//   - Latch gnt; go to GRANT on the next edge.
// - GRANT:
//   - ramaddr = addr[gnt]; ramstore = store[gnt].
//   - ramWEN = wen[gnt]; ramREN = ren[gnt] & ~wen[gnt].
//   - All other requesters see rwait=1; load[other]=0.
// - Completion:
//   - Completes when ramstate==ACCESS and req[gnt]==1.
//   - That cycle: rwait[gnt]=0, load[gnt]=ramload (reads; 0 on writes).
//   - Next edge: ptr<=gnt, state<=IDLE.
// - Abandon: req[gnt]==0 in GRANT -> IDLE next edge; ptr unchanged, no rwait pulse, RAM enables 0 that cycle.
// - ERROR on ramstate: treated as not-ACCESS; grant holds and the request is retried until ACCESS.
// - Latency:
//   - Minimum 2 cycles from request assertion to rwait low (1 arbitration + 1 ACCESS).
//   - A requester re-requesting right after completion waits at least one IDLE cycle.
// - Fairness: after completing, a requester is last in priority; with all NREQ requesting, service is i, i+1, ... mod NREQ.
// - Simultaneous events: new requests during GRANT are ignored until IDLE; requester index wraps NREQ-1 -> 0.
// - Mid-operation reset: async nRST forces IDLE and drops ramREN/ramWEN immediately; any in-flight access is discarded.
// - Outputs are combinational from state/gnt and inputs; no combinational path from ren/wen to gnt_id.
// TESTING
// - Reset: nRST=0 mid-GRANT -> ramREN=ramWEN=0 and busy=0 same cycle; gnt_id=0; ptr=NREQ-1 (first grant goes to req 0).
// - Single read:
//   - Stimulus: ren[1]=1, addr[1]=0x40, RAM returns 0xDEADBEEF after 3 BUSY cycles.
//   - Required: gnt_id=1, ramREN=1, ramaddr=0x40; rwait[1]=0 for one cycle with load[1]=0xDEADBEEF.
// - Round-robin: all requesters continuously request (NREQ=2, ACCESS immediate) -> grants alternate 0,1,0,1; no requester served twice in a row.
// - Write priority:
//   - Stimulus: ren[0]=wen[0]=1, store[0]=0x12345678.
//   - Required: ramWEN=1, ramREN=0, ramstore=0x12345678; load[0]=0 at completion.
// - Abandon: ren[0] dropped during BUSY -> IDLE next cycle; no rwait pulse; pending ren[1] granted next.
// - ERROR/retry: ramstate=ERROR for 2 cycles then ACCESS -> grant held throughout; exactly one rwait pulse on the granted requester.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that multiplexes NREQ single-word cache-side requesters onto one RAM port.
// The grant is registered and held until the RAM reports ACCESS; the requester just served drops to lowest priority.
module ram_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      ren,
  input  logic [NREQ-1:0]      wen,
  input  logic [NREQ*32-1:0]   addr,
  input  logic [NREQ*32-1:0]   store,
  output logic [NREQ-1:0]      rwait,
  output logic [NREQ*32-1:0]   load,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 busy,
  output logic [IDW-1:0]       gnt_id
);

  localparam logic       IDLE  = 1'b0;
  localparam logic       GRANT = 1'b1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  logic           state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;

  logic [NREQ-1:0] req;
  logic            sel_ren, sel_wen, sel_req;
  logic [31:0]     sel_addr, sel_store;
  logic            pick_found;
  logic [IDW-1:0]  pick, idx;
  logic            in_grant, done;

  always_comb begin
    req       = ren | wen;
    sel_ren   = 1'b0;
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_store = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == IDW'(i)) begin
        sel_ren   = ren[i];
        sel_wen   = wen[i];
        sel_addr  = addr[i*32 +: 32];
        sel_store = store[i*32 +: 32];
      end
    end
    sel_req = sel_ren | sel_wen;

    // Search starts one past the last completed requester so it ends up last in line.
    pick_found = 1'b0;
    pick       = ptr_q;
    idx        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    in_grant = (state_q == GRANT);
    done     = in_grant && sel_req && (ramstate == RS_ACCESS);

    busy     = in_grant;
    gnt_id   = in_grant ? gnt_q : '0;
    ramWEN   = in_grant & sel_wen;
    ramREN   = in_grant & sel_ren & ~sel_wen;
    ramaddr  = in_grant ? sel_addr : '0;
    ramstore = in_grant ? sel_store : '0;

    rwait = '1;
    load  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (done && gnt_q == IDW'(i)) begin
        rwait[i] = 1'b0;
        if (!sel_wen) load[i*32 +: 32] = ramload;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d = GRANT;
        gnt_d   = pick;
      end
    end else begin
      // ERROR and BUSY both simply hold the grant; a dropped request abandons without moving the pointer.
      if (done) begin
        state_d = IDLE;
        ptr_d   = gnt_q;
      end else if (!sel_req) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a request/grant model built from the arbitration rules.
module tb_ram_rr_arbiter;
  localparam int NREQ = 2;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic              CLK;
  logic              nRST;
  logic [NREQ-1:0]   ren, wen;
  logic [NREQ*32-1:0] addr, store;
  logic [NREQ-1:0]   rwait;
  logic [NREQ*32-1:0] load;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
  logic              busy;
  logic [0:0]        gnt_id;

  int total = 0;
  int bad   = 0;

  ram_rr_arbiter #(.NREQ(NREQ)) dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .store(store),
    .rwait(rwait), .load(load), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .busy(busy), .gnt_id(gnt_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int          nrec;
  logic [0:0]  got [4];

  initial begin
    nRST = 1'b0; ren = '0; wen = '0; addr = '0; store = '0;
    ramload = '0; ramstate = FREE;

    fork
      begin : model_check
        bit         mb, nb, r, w, dn;
        int         mg, ml, ng, nl, c;
        logic [NREQ-1:0]    e_rwait;
        logic [NREQ*32-1:0] e_load;
        mb = 0; mg = 0; ml = NREQ - 1;
        forever begin
          @(negedge CLK);
          if (!nRST) begin mb = 0; mg = 0; ml = NREQ - 1; end
          e_rwait = '1; e_load = '0; r = 0; w = 0; dn = 0;
          nb = mb; ng = mg; nl = ml;
          if (mb) begin
            r  = ren[mg];
            w  = wen[mg];
            dn = (r || w) && (ramstate == ACCESS);
            if (dn) begin
              e_rwait[mg] = 1'b0;
              if (!w) e_load[mg*32 +: 32] = ramload;
              nb = 0; nl = mg;
            end else if (!(r || w)) begin
              nb = 0;
            end
          end else begin
            for (int k = 1; k <= NREQ; k++) begin
              c = (ml + k) % NREQ;
              if (!nb && (ren[c] || wen[c])) begin nb = 1; ng = c; end
            end
          end
          chk("m_busy",   64'(busy),   64'(mb));
          chk("m_gnt",    64'(gnt_id), mb ? 64'(mg) : 64'(0));
          chk("m_rwait",  64'(rwait),  64'(e_rwait));
          chk("m_load",   64'(load),   64'(e_load));
          chk("m_ramWEN", 64'(ramWEN), 64'(mb && w));
          chk("m_ramREN", 64'(ramREN), 64'(mb && r && !w));
          if (mb) begin
            chk("m_ramaddr",  64'(ramaddr),  64'(addr[mg*32 +: 32]));
            chk("m_ramstore", 64'(ramstore), 64'(store[mg*32 +: 32]));
          end
          @(posedge CLK);
          if (!nRST) begin mb = 0; mg = 0; ml = NREQ - 1; end
          else begin mb = nb; mg = ng; ml = nl; end
        end
      end
    join_none

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_gnt",    64'(gnt_id), 64'(0));
    chk("rst_rwait",  64'(rwait),  64'(2'b11));
    chk("rst_load",   64'(load),   64'(0));
    chk("rst_ramREN", 64'(ramREN), 64'(0));
    chk("rst_ramWEN", 64'(ramWEN), 64'(0));
    chk("rst_ramaddr", 64'(ramaddr), 64'(0));
    nRST = 1'b1;

    // Single read with three BUSY cycles before ACCESS
    ren = 2'b10; addr[63:32] = 32'h40; ramstate = BUSY;
    step();
    chk("rd_gnt",    64'(gnt_id),  64'(1));
    chk("rd_ramREN", 64'(ramREN),  64'(1));
    chk("rd_addr",   64'(ramaddr), 64'h40);
    chk("rd_wait",   64'(rwait),   64'(2'b11));
    step(); step();
    chk("rd_hold",   64'(rwait),   64'(2'b11));
    step();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    chk("rd_rwait",  64'(rwait),        64'(2'b01));
    chk("rd_load",   64'(load[63:32]),  64'hDEADBEEF);
    step();
    ren = '0; ramstate = FREE;
    chk("rd_idle",   64'(busy),  64'(0));
    chk("rd_nowait", 64'(rwait), 64'(2'b11));

    // Round-robin with both requesting and immediate ACCESS
    ren = 2'b11; ramstate = ACCESS; nrec = 0;
    for (int cy = 0; cy < 20 && nrec < 4; cy++) begin
      step();
      if (busy && rwait != 2'b11) begin got[nrec] = gnt_id; nrec++; end
    end
    chk("rr_count", 64'(nrec), 64'(4));
    chk("rr_g0", 64'(got[0]), 64'(0));
    chk("rr_g1", 64'(got[1]), 64'(1));
    chk("rr_g2", 64'(got[2]), 64'(0));
    chk("rr_g3", 64'(got[3]), 64'(1));
    step();
    ren = '0; ramstate = FREE;

    // Abandon: requester 0 drops during BUSY, pending requester 1 follows
    ren = 2'b11; ramstate = BUSY;
    step();
    chk("ab_gnt0", 64'(gnt_id), 64'(0));
    step();
    ren = 2'b10;
    #1;
    chk("ab_nopulse", 64'(rwait),  64'(2'b11));
    chk("ab_noren",   64'(ramREN), 64'(0));
    step();
    chk("ab_idle",    64'(busy),   64'(0));
    chk("ab_wait",    64'(rwait),  64'(2'b11));
    step();
    chk("ab_gnt1",    64'(gnt_id), 64'(1));
    ramstate = ACCESS;
    #1;
    chk("ab_done",    64'(rwait),  64'(2'b01));
    step();
    ren = '0; ramstate = FREE;

    // Write wins over read on the same requester
    ren = 2'b01; wen = 2'b01; store[31:0] = 32'h12345678; ramstate = BUSY;
    step();
    chk("wr_gnt",    64'(gnt_id),   64'(0));
    chk("wr_ramWEN", 64'(ramWEN),   64'(1));
    chk("wr_ramREN", 64'(ramREN),   64'(0));
    chk("wr_store",  64'(ramstore), 64'h12345678);
    ramstate = ACCESS; ramload = 32'hAAAA5555;
    #1;
    chk("wr_rwait",  64'(rwait),       64'(2'b10));
    chk("wr_load",   64'(load[31:0]),  64'(0));
    step();
    ren = '0; wen = '0; ramstate = FREE;

    // Asynchronous reset in the middle of a grant
    ren = 2'b10; ramstate = BUSY;
    step();
    chk("mr_gnt1", 64'(gnt_id), 64'(1));
    #1 nRST = 1'b0;
    #1;
    chk("mr_ramREN", 64'(ramREN), 64'(0));
    chk("mr_ramWEN", 64'(ramWEN), 64'(0));
    chk("mr_busy",   64'(busy),   64'(0));
    chk("mr_gntid",  64'(gnt_id), 64'(0));
    ren = 2'b11;
    step();
    nRST = 1'b1;
    step();
    chk("mr_first0", 64'(gnt_id), 64'(0));
    ramstate = ACCESS;
    #1;
    chk("mr_done",   64'(rwait),  64'(2'b10));
    step();
    ren = '0; ramstate = FREE;

    // ERROR for two cycles, then ACCESS
    ren = 2'b10; ramstate = ERROR;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("er_gnt",  64'(gnt_id), 64'(1));
      chk("er_wait", 64'(rwait),  64'(2'b11));
      step();
    end
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    #1;
    chk("er_gnt3",  64'(gnt_id),       64'(1));
    chk("er_pulse", 64'(rwait),        64'(2'b01));
    chk("er_load",  64'(load[63:32]),  64'h0BADF00D);
    step();
    ren = '0;
    chk("er_after", 64'(rwait), 64'(2'b11));
    step();
    ramstate = FREE;

    // Randomized traffic checked by the model
    for (int cy = 0; cy < 3000; cy++) begin
      if ($urandom_range(0, 9) < 3) ren = NREQ'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 2) wen = NREQ'($urandom_range(0, 3)) & NREQ'($urandom_range(0, 3));
      addr     = {$urandom, $urandom};
      store    = {$urandom, $urandom};
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      if (!nRST) nRST = 1'b1;
      else if ($urandom_range(0, 299) == 0) nRST = 1'b0;
      step();
    end
    nRST = 1'b1; ren = '0; wen = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
